pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 64, payload width (e.g. {instruction, next_address}).
- BUBBLE_VAL, default 0, value driven on out_data when out_valid=0.
- CNT_W, default 16, stall-counter width.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  discard all held entries (branch/jump kill).
REQ-005 in_valid  input  1  upstream presents in_data.
REQ-006 in_data  input  DATA_W  upstream payload.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 out_valid  output  1  out_data holds a live entry.
REQ-009 out_data  output  DATA_W  oldest held entry, else BUBBLE_VAL.
REQ-010 out_ready  input  1  downstream consumes this cycle.
REQ-011 occupancy  output  2  held entries, 0..2.
REQ-012 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-013 A transfer SHALL occur on the input side when in_valid & in_ready, and on the output side when out_valid & out_ready, both sampled at the rising clk edge.
REQ-014 Storage SHALL be a 2-entry skid buffer: a main register (drives out_data) and a skid register.
REQ-015 The FSM SHALL have three states: EMPTY (0 entries), ONE (main full), TWO (main and skid full); occupancy SHALL equal 0/1/2 respectively.
REQ-016 Transitions SHALL be:
- EMPTY + in xfer -> ONE.
- ONE + in xfer without out xfer -> TWO, with data into skid.
- ONE + out xfer without in xfer -> EMPTY.
- ONE + both -> ONE, with main loaded from in_data.
- TWO + out xfer -> ONE, with main loaded from skid.
- All other cases hold.
REQ-017 in_ready SHALL be a register output, equal to (state != TWO); it SHALL have no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 exactly in ONE or TWO; out_data SHALL equal BUBBLE_VAL when out_valid=0.
REQ-019 Latency SHALL be 1 cycle: data accepted at edge N SHALL appear on out_data after edge N when the stage was EMPTY.
REQ-020 Ordering SHALL be strict FIFO; no entry SHALL be lost or duplicated.
REQ-021 In TWO, in_data SHALL be ignored regardless of in_valid.
REQ-022 flush=1 SHALL force EMPTY at the next edge, with out_data=BUBBLE_VAL; flush SHALL override a same-cycle input transfer, and that input beat is dropped.
REQ-023 A same-cycle output transfer under flush SHALL still count as consumed by downstream.
REQ-024 stall_cnt SHALL increment by 1 on every edge where out_valid & ~out_ready, and saturate at 2^CNT_W-1 without wrapping.
REQ-025 flush SHALL NOT clear stall_cnt.

Reset
REQ-026 When reset=1 at a rising edge, the stage SHALL go to EMPTY; both registers SHALL hold BUBBLE_VAL; in_ready=1, out_valid=0, occupancy=0, stall_cnt=0.
REQ-027 Reset SHALL take priority over flush and all transfers.
REQ-028 Reset asserted mid-operation SHALL discard held entries identically to flush and additionally clear stall_cnt.
REQ-029 out_data SHALL never present X after the first reset edge.

Structure
REQ-030 A shared package pipe_pkg SHALL hold:
- the state enum (ST_EMPTY, ST_ONE, ST_TWO);
- DEFAULT_DATA_W=64;
- DEFAULT_CNT_W=16.
REQ-031 The saturating counter SHALL be a sub-module named sat_counter (parameter W; ports clk, reset, inc, count).
REQ-032 All other logic SHALL reside in pipe_stage_reg; it SHALL contain no latches and no combinational feedback from out_ready to in_ready.

Verification
REQ-033 Reset: hold reset 2 cycles with in_valid=1, in_data=0xDEAD -> after release out_valid=0, out_data=0, in_ready=1, occupancy=0.
REQ-034 Streaming: out_ready=1; push 0x11,0x22,0x33 on consecutive cycles -> out_data shows 0x11,0x22,0x33 one cycle later each; occupancy stays 1.
REQ-035 Back-pressure: out_ready=0; push 0xA1,0xA2,0xA3 -> occupancy=2, in_ready=0 after second accept; 0xA3 not accepted; raise out_ready -> outputs 0xA1,0xA2 in order.
REQ-036 Flush: occupancy=2 holding 0xB1,0xB2, assert flush with in_valid=1, in_data=0xB3 -> next cycle occupancy=0, out_data=0, 0xB3 never appears.
REQ-037 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds; flush -> stall_cnt unchanged; reset -> 0.
REQ-038 Random: 10,000 cycles of random in_valid/out_ready/flush checked against a scoreboard queue -> zero ordering mismatches; in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates on the edge after inc.
// Backpressure: none; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with flush and stall counting.
// Latency: 1 cycle from input accept to out_data when empty.
// Backpressure: in_ready is registered and drops only when both entries are full.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int                 CNT_W      = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;
  assign in_ready = in_ready_q;

  // in_ready is derived from the next state so it never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_ONE;
      ST_ONE: begin
        if (in_xfer && !out_xfer)      state_d = ST_TWO;
        else if (out_xfer && !in_xfer) state_d = ST_EMPTY;
      end
      ST_TWO:   if (out_xfer) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_comb begin
    out_valid = 1'b0;
    occupancy = 2'd0;
    unique case (state_q)
      ST_ONE:  begin out_valid = 1'b1; occupancy = 2'd1; end
      ST_TWO:  begin out_valid = 1'b1; occupancy = 2'd2; end
      default: begin out_valid = 1'b0; occupancy = 2'd0; end
    endcase
  end

  assign out_data = out_valid ? main_q : BUBBLE_VAL;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (in_xfer) main_q <= in_data;
        ST_ONE: begin
          if (in_xfer && out_xfer) main_q <= in_data;
          else if (in_xfer)        skid_q <= in_data;
        end
        ST_TWO:   if (out_xfer) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule
